// File: rtl/ifft_out_scaler_v2_if.sv
// Sample stream between IFFT source port and scaler, and scaler and IDCT post-processing.
// One beat = I/Q pair plus sop/eop/error framing and the frame size.
interface ifft_out_scaler_v2_if #(
  parameter int W = 16
);
  logic                valid;
  logic                ready;
  logic [1:0]          error;
  logic                sop;
  logic                eop;
  logic signed [W-1:0] re;
  logic signed [W-1:0] im;
  logic [11:0]         fftpts;

  modport master (output valid, error, sop, eop, re, im, fftpts, input ready);
  modport slave  (input valid, error, sop, eop, re, im, fftpts, output ready);
endinterface

// File: rtl/ifft_out_scaler_v2.sv
// Post-IFFT I/Q scaler: per-frame arithmetic right shift, rounding, saturation, frame checks.
// Latency 1 clk; output register plus one skid entry, sink ready drops once the skid fills.
module ifft_out_scaler_v2 #(
  parameter int wDataIn    = 28,
  parameter int wDataOut   = 16,
  parameter int wShift     = 5,
  parameter int ROUND_MODE = 0,
  parameter int wCnt       = 12
) (
  input  logic                clk,
  input  logic                rst_n_sync,
  input  logic [wShift-1:0]   cfg_shift,
  ifft_out_scaler_v2_if.slave  sink,
  ifft_out_scaler_v2_if.master source,
  output logic                overflow,
  output logic                frame_done,
  output logic [wCnt-1:0]     frame_ovf_cnt
);

  localparam int WX = wDataIn + 1;
  localparam logic signed [WX-1:0] SAT_HI = {{(WX-wDataOut+1){1'b0}}, {(wDataOut-1){1'b1}}};
  localparam logic signed [WX-1:0] SAT_LO = {{(WX-wDataOut+1){1'b1}}, {(wDataOut-1){1'b0}}};

  typedef enum logic {IDLE, FRAME} state_t;

  typedef struct packed {
    logic [1:0]          err;
    logic                sop;
    logic                eop;
    logic                sat;
    logic [11:0]         pts;
    logic [wDataOut-1:0] re;
    logic [wDataOut-1:0] im;
  } beat_t;

  // Returns {clamped, value}; clamping is judged on the rounded value, not the output code.
  function automatic logic [wDataOut:0] scale(input logic [wDataIn-1:0] x,
                                              input logic [wShift-1:0]  s);
    logic signed [WX-1:0] xe, half, trunc, r;
    xe = {x[wDataIn-1], x};
    r  = xe;
    if (s != '0) begin
      half  = WX'(1) << (s - 1'b1);
      trunc = xe >>> s;
      if (ROUND_MODE == 1 && ((xe & ((half <<< 1) - WX'(1))) == half) && !trunc[0])
        r = trunc;
      else
        r = (xe + half) >>> s;
    end
    if (r > SAT_HI)
      scale = {1'b1, 1'b0, {(wDataOut-1){1'b1}}};
    else if (r < SAT_LO)
      scale = {1'b1, 1'b1, {(wDataOut-1){1'b0}}};
    else
      scale = {1'b0, r[wDataOut-1:0]};
  endfunction

  state_t            state;
  logic [wShift-1:0] shift_q, shift_cl, shift_use;
  logic [11:0]       pts_q;
  beat_t             out_q, skid_q, nb;
  logic              out_vld, skid_vld, rdy_q;
  logic [wCnt-1:0]   cnt, cnt_inc;
  logic              in_fire, out_fire, sat_i, sat_q;
  logic [1:0]        frm_err;

  always_comb begin
    in_fire   = sink.valid & rdy_q;
    out_fire  = out_vld & source.ready;
    shift_cl  = (32'(cfg_shift) > wDataIn - 1) ? wShift'(wDataIn - 1) : cfg_shift;
    shift_use = sink.sop ? shift_cl : shift_q;
    frm_err   = 2'b00;
    if (state == IDLE && !sink.sop)
      frm_err = 2'b01;
    else if (state == FRAME && sink.sop)
      frm_err = 2'b10;
    nb     = '0;
    sat_i  = 1'b0;
    sat_q  = 1'b0;
    {sat_i, nb.re} = scale(sink.re, shift_use);
    {sat_q, nb.im} = scale(sink.im, shift_use);
    nb.sat = sat_i | sat_q;
    nb.err = (sink.error != 2'b00) ? sink.error : frm_err;
    nb.sop = sink.sop;
    nb.eop = sink.eop;
    nb.pts = sink.sop ? sink.fftpts : pts_q;
    cnt_inc = (out_q.sat && cnt != '1) ? cnt + 1'b1 : cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      state    <= IDLE;
      shift_q  <= '0;
      pts_q    <= '0;
      out_q    <= '0;
      skid_q   <= '0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      if (in_fire) begin
        if (sink.sop) begin
          shift_q <= shift_cl;
          pts_q   <= sink.fftpts;
        end
        case (state)
          IDLE:    if (sink.sop && !sink.eop) state <= FRAME;
          FRAME:   if (sink.eop) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      // Output slot frees: drain skid first so order is preserved.
      if (!out_vld || source.ready) begin
        rdy_q <= 1'b1;
        if (skid_vld) begin
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= 1'b0;
        end else begin
          out_vld <= in_fire;
          if (in_fire) out_q <= nb;
        end
      end else if (in_fire) begin
        skid_q   <= nb;
        skid_vld <= 1'b1;
        rdy_q    <= 1'b0;
      end
      if (out_fire)
        cnt <= out_q.eop ? '0 : cnt_inc;
    end
  end

  assign sink.ready     = rdy_q;
  assign source.valid   = out_vld;
  assign source.error   = out_q.err;
  assign source.sop     = out_q.sop;
  assign source.eop     = out_q.eop;
  assign source.re      = out_q.re;
  assign source.im      = out_q.im;
  assign source.fftpts  = out_q.pts;
  assign overflow       = out_vld & out_q.sat;
  assign frame_done     = out_fire & out_q.eop;
  assign frame_ovf_cnt  = frame_done ? cnt_inc : '0;

endmodule

// File: tb/tb_ifft_out_scaler_v2.sv
// Scoreboard bench for ifft_out_scaler_v2: one instance per rounding mode, same stimulus.
module tb_ifft_out_scaler_v2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  cfg_shift;
  logic        overflow0, overflow1, frame_done0, frame_done1;
  logic [11:0] cnt0, cnt1;

  ifft_out_scaler_v2_if #(.W(28)) snk();
  ifft_out_scaler_v2_if #(.W(16)) src0();
  ifft_out_scaler_v2_if #(.W(28)) snk1();
  ifft_out_scaler_v2_if #(.W(16)) src1();

  assign snk1.valid  = snk.valid;
  assign snk1.error  = snk.error;
  assign snk1.sop    = snk.sop;
  assign snk1.eop    = snk.eop;
  assign snk1.re     = snk.re;
  assign snk1.im     = snk.im;
  assign snk1.fftpts = snk.fftpts;
  assign src1.ready  = src0.ready;

  ifft_out_scaler_v2 #(.ROUND_MODE(0)) dut0 (
    .clk(clk), .rst_n_sync(rst_n), .cfg_shift(cfg_shift), .sink(snk), .source(src0),
    .overflow(overflow0), .frame_done(frame_done0), .frame_ovf_cnt(cnt0));
  ifft_out_scaler_v2 #(.ROUND_MODE(1)) dut1 (
    .clk(clk), .rst_n_sync(rst_n), .cfg_shift(cfg_shift), .sink(snk1), .source(src1),
    .overflow(overflow1), .frame_done(frame_done1), .frame_ovf_cnt(cnt1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] re, im, re1, im1;
    logic [1:0]  err;
    logic        sop, eop, ovf, done;
    logic [11:0] pts, cnt;
  } exp_t;

  exp_t q0[$], q1[$];
  int   n_chk = 0, n_pass = 0, done_total = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  function automatic exp_t mk(input logic [15:0] re, im, re1, im1, input logic [1:0] err,
                              input logic sop, eop, ovf, done, input logic [11:0] pts, cnt);
    exp_t e;
    e = '{re: re, im: im, re1: re1, im1: im1, err: err, sop: sop, eop: eop,
          ovf: ovf, done: done, pts: pts, cnt: cnt};
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    if (frame_done0) done_total++;
    if (rst_n && src0.valid && src0.ready) begin
      if (q0.size() == 0) check("extra_beat_m0", 1, 0);
      else begin
        e = q0.pop_front();
        a = e;
        a.re = src0.re; a.im = src0.im; a.err = src0.error;
        a.sop = src0.sop; a.eop = src0.eop; a.ovf = overflow0;
        a.done = frame_done0; a.pts = src0.fftpts;
        a.cnt = frame_done0 ? cnt0 : 12'd0;
        check("beat_m0", a, e);
      end
    end
    if (rst_n && src1.valid && src1.ready) begin
      if (q1.size() == 0) check("extra_beat_m1", 1, 0);
      else begin
        e = q1.pop_front();
        a = e;
        a.re1 = src1.re; a.im1 = src1.im;
        check("beat_m1", a, e);
      end
    end
  end

  task automatic send(input logic sop, eop, input logic [1:0] err, input logic [4:0] sh,
                      input logic signed [27:0] re, im, input logic [11:0] pts, input exp_t e);
    bit ok = 0;
    snk.valid = 1'b1; snk.sop = sop; snk.eop = eop; snk.error = err;
    snk.re = re; snk.im = im; snk.fftpts = pts; cfg_shift = sh;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (snk.ready) begin ok = 1; break; end
    end
    if (!ok) check("sink_ready_timeout", 0, 1);
    @(posedge clk); #1;
    q0.push_back(e);
    q1.push_back(e);
    snk.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_shift = '0; src0.ready = 1'b1;
    snk.valid = 1'b0; snk.sop = 1'b0; snk.eop = 1'b0; snk.error = 2'b00;
    snk.re = '0; snk.im = '0; snk.fftpts = '0;
    idle(3);
    check("reset_outs", {src0.valid, snk.ready, overflow0, frame_done0, cnt0, src0.re}, '0);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_reset", snk.ready, 1);

    // Rounding and saturation, s=8
    send(1, 0, 2'b00, 8, 28'sd384, 28'sd640, 12'd64,
         mk(16'd2, 16'd3, 16'd2, 16'd2, 2'b00, 1, 0, 0, 0, 12'd64, 0));
    check("latency_1clk", src0.valid, 1);
    send(0, 0, 2'b00, 8, -28'sd384, 28'sd896, 12'd0,
         mk(16'hFFFF, 16'd4, 16'hFFFE, 16'd4, 2'b00, 0, 0, 0, 0, 12'd64, 0));
    send(0, 1, 2'b00, 8, 28'sd8388480, 28'sh8000000, 12'd0,
         mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 2'b00, 0, 1, 1, 1, 12'd64, 1));
    idle(3);

    // Stall: source_ready low for 3 clocks under continuous input
    fork
      for (int k = 1; k <= 6; k++)
        send(k == 1, k == 6, 2'b00, 8, 28'(k * 256), -28'(k * 256), 12'd16,
             mk(16'(k), -16'(k), 16'(k), -16'(k), 2'b00, k == 1, k == 6, 0, k == 6, 12'd16, 0));
      begin
        @(posedge clk); #1 src0.ready = 1'b0;
        @(negedge clk); check("stall_rdy_clk1", snk.ready, 1);
        @(negedge clk); check("stall_rdy_clk2", snk.ready, 0);
        @(negedge clk); check("stall_rdy_clk3", snk.ready, 0);
        @(posedge clk); #1 src0.ready = 1'b1;
      end
    join
    idle(4);

    // 8-beat frame, beats 2,5,7 saturate
    send(1, 0, 2'b00, 8, 28'sd512, 28'sd0, 12'd8, mk(2, 0, 2, 0, 2'b00, 1, 0, 0, 0, 12'd8, 0));
    send(0, 0, 2'b00, 8, 28'sd8388480, 28'sd0, 12'd0,
         mk(16'h7FFF, 0, 16'h7FFF, 0, 2'b00, 0, 0, 1, 0, 12'd8, 0));
    send(0, 0, 2'b00, 8, 28'sd768, 28'sd0, 12'd0, mk(3, 0, 3, 0, 2'b00, 0, 0, 0, 0, 12'd8, 0));
    send(0, 0, 2'b00, 8, 28'sd1024, 28'sd0, 12'd0, mk(4, 0, 4, 0, 2'b00, 0, 0, 0, 0, 12'd8, 0));
    send(0, 0, 2'b00, 8, 28'sh8000000, 28'sd0, 12'd0,
         mk(16'h8000, 0, 16'h8000, 0, 2'b00, 0, 0, 1, 0, 12'd8, 0));
    send(0, 0, 2'b00, 8, 28'sd1280, 28'sd0, 12'd0, mk(5, 0, 5, 0, 2'b00, 0, 0, 0, 0, 12'd8, 0));
    send(0, 0, 2'b00, 8, 28'sd0, 28'sd8388608, 12'd0,
         mk(0, 16'h7FFF, 0, 16'h7FFF, 2'b00, 0, 0, 1, 0, 12'd8, 0));
    send(0, 1, 2'b00, 8, 28'sd1536, 28'sd0, 12'd0, mk(6, 0, 6, 0, 2'b00, 0, 1, 0, 1, 12'd8, 3));
    idle(2);

    // Framing errors and upstream error pass-through
    send(0, 0, 2'b00, 3, 28'sd768, 28'sd0, 12'd0, mk(3, 0, 3, 0, 2'b01, 0, 0, 0, 0, 12'd8, 0));
    send(1, 0, 2'b00, 8, 28'sd256, 28'sd0, 12'd32, mk(1, 0, 1, 0, 2'b00, 1, 0, 0, 0, 12'd32, 0));
    send(1, 0, 2'b00, 4, 28'sd24, 28'sd40, 12'd48, mk(2, 3, 2, 2, 2'b10, 1, 0, 0, 0, 12'd48, 0));
    send(0, 1, 2'b11, 8, 28'sd40, 28'sd0, 12'd0, mk(3, 0, 2, 0, 2'b11, 0, 1, 0, 1, 12'd48, 0));
    idle(2);

    // Shift clamp to 27, shift 0, clamp-event versus full-scale values
    send(1, 1, 2'b00, 31, 28'sd67108864, -28'sd67108864, 12'd100,
         mk(1, 0, 0, 0, 2'b00, 1, 1, 0, 1, 12'd100, 0));
    send(1, 1, 2'b00, 0, 28'sd100, 28'sd40000, 12'd5,
         mk(100, 16'h7FFF, 100, 16'h7FFF, 2'b00, 1, 1, 1, 1, 12'd5, 1));
    send(1, 1, 2'b00, 0, 28'sd32767, -28'sd32768, 12'd6,
         mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 2'b00, 1, 1, 0, 1, 12'd6, 0));
    idle(2);

    // Reset mid-frame with one beat held and one in the skid
    send(1, 0, 2'b00, 8, 28'sd8388480, 28'sd0, 12'd9,
         mk(16'h7FFF, 0, 16'h7FFF, 0, 2'b00, 1, 0, 1, 0, 12'd9, 0));
    idle(1);
    src0.ready = 1'b0;
    send(0, 0, 2'b00, 8, 28'sd256, 28'sd0, 12'd0, mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 12'd9, 0));
    send(0, 0, 2'b00, 8, 28'sd512, 28'sd0, 12'd0, mk(2, 0, 2, 0, 2'b00, 0, 0, 0, 0, 12'd9, 0));
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("rst_mid_valid", src0.valid, 0);
    q0.delete();
    q1.delete();
    src0.ready = 1'b1;
    idle(3);
    send(0, 0, 2'b00, 8, 28'sd5, -28'sd3, 12'd0,
         mk(5, 16'hFFFD, 5, 16'hFFFD, 2'b01, 0, 0, 0, 0, 12'd0, 0));
    send(1, 1, 2'b00, 0, 28'sd7, 28'sd0, 12'd4, mk(7, 0, 7, 0, 2'b00, 1, 1, 0, 1, 12'd4, 0));

    for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    idle(2);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    check("frame_done_total", done_total, 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
